// File: rtl/ddr_rd_burst_gen_if.sv
// Command, AXI read (register-slice side) and data-stream signals of ddr_rd_burst_gen.
// DDR_RD_BURST_STAT_EN adds the statistics outputs.
interface ddr_rd_burst_gen_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [63:0]  cmd_addr;
    logic [23:0]  cmd_beats;
    logic         m_axi_cu_arvalid_rs;
    logic [63:0]  m_axi_cu_araddr_rs;
    logic [7:0]   m_axi_cu_arlen_rs;
    logic         m_axi_cu_arready_rs;
    logic         m_axi_cu_rvalid_rs;
    logic [511:0] m_axi_cu_rdata_rs;
    logic         m_axi_cu_rlast_rs;
    logic [1:0]   m_axi_cu_rresp_rs;
    logic         m_axi_cu_rready_rs;
    logic         d_valid;
    logic [511:0] d_data;
    logic         d_last;
    logic         d_ready;
    logic         done;
    logic         err;
`ifdef DDR_RD_BURST_STAT_EN
    logic [31:0]  stat_bursts;
    logic [31:0]  stat_err_beats;
`endif

    modport master (
        input  cmd_valid, cmd_addr, cmd_beats,
        output cmd_ready,
        output m_axi_cu_arvalid_rs, m_axi_cu_araddr_rs, m_axi_cu_arlen_rs,
        input  m_axi_cu_arready_rs,
        input  m_axi_cu_rvalid_rs, m_axi_cu_rdata_rs, m_axi_cu_rlast_rs, m_axi_cu_rresp_rs,
        output m_axi_cu_rready_rs,
        output d_valid, d_data, d_last,
        input  d_ready,
        output done, err
`ifdef DDR_RD_BURST_STAT_EN
        , output stat_bursts, stat_err_beats
`endif
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_beats,
        input  cmd_ready,
        input  m_axi_cu_arvalid_rs, m_axi_cu_araddr_rs, m_axi_cu_arlen_rs,
        output m_axi_cu_arready_rs,
        output m_axi_cu_rvalid_rs, m_axi_cu_rdata_rs, m_axi_cu_rlast_rs, m_axi_cu_rresp_rs,
        input  m_axi_cu_rready_rs,
        input  d_valid, d_data, d_last,
        output d_ready,
        input  done, err
`ifdef DDR_RD_BURST_STAT_EN
        , input stat_bursts, stat_err_beats
`endif
    );
endinterface

// File: rtl/ddr_rd_burst_gen.sv
// Splits a read command into 4 KB-safe AXI INCR bursts with an outstanding cap and
// streams the read data back. DDR_RD_BURST_STAT_EN enables burst/error-beat counters.
module ddr_rd_burst_gen #(
    parameter int MAX_BURST       = 64,
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic               user_clk,
    input  logic               reset_n,
    ddr_rd_burst_gen_if.master bus
);
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ISSUE = 2'd1, S_DRAIN = 2'd2} state_t;

    state_t       r_state, w_state_nxt;
    logic [63:0]  r_addr;
    logic [23:0]  r_beats_left;
    logic [23:0]  r_rx_left;
    logic [8:0]   r_outstanding;
    logic         r_arvalid;
    logic [63:0]  r_araddr;
    logic [7:0]   r_arlen;
    logic         r_done;
    logic         r_err;

    logic         w_cmd_ready;
    logic         w_accept;
    logic         w_ar_hs;
    logic         w_r_hs;
    logic         w_active;
    logic         w_r_cnt;
    logic         w_rx_last;
    logic         w_cmd_done;
    logic         w_issue;
    logic [6:0]   w_to_4k;
    logic [8:0]   w_n;
    logic [8:0]   w_hs_beats;

    assign w_accept   = bus.cmd_valid & w_cmd_ready;
    assign w_ar_hs    = r_arvalid & bus.m_axi_cu_arready_rs;
    assign w_r_hs     = bus.m_axi_cu_rvalid_rs & bus.m_axi_cu_rready_rs;
    assign w_active   = (r_state != S_IDLE);
    assign w_r_cnt    = w_r_hs & w_active;
    assign w_rx_last  = (r_rx_left == 24'd1);
    assign w_cmd_done = w_r_cnt & w_rx_last & (r_state == S_DRAIN);
    assign w_hs_beats = {1'b0, r_arlen} + 9'd1;
    assign w_to_4k    = 7'd64 - {1'b0, r_addr[11:6]};
    assign w_issue    = (r_state == S_ISSUE) & ~r_arvalid & (r_beats_left != 24'd0) &
                        (r_outstanding < 9'(MAX_OUTSTANDING));

    // Burst length: smallest of remaining beats, MAX_BURST and beats left in the 4 KB page
    always_comb begin
        w_n = 9'(MAX_BURST);
        if ({2'b00, w_to_4k} < w_n) w_n = {2'b00, w_to_4k};
        if (r_beats_left < {15'd0, w_n}) w_n = r_beats_left[8:0];
    end

    always_ff @(posedge user_clk) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cmd_ready = 1'b1;
                if (bus.cmd_valid && (bus.cmd_beats != 24'd0)) w_state_nxt = S_ISSUE;
            end
            S_ISSUE: if (w_ar_hs && (r_beats_left == {15'd0, w_hs_beats})) w_state_nxt = S_DRAIN;
            S_DRAIN: if (w_cmd_done) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (!reset_n) begin
            r_addr        <= '0;
            r_beats_left  <= '0;
            r_rx_left     <= '0;
            r_outstanding <= '0;
            r_arvalid     <= 1'b0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_done <= w_cmd_done;
            if (w_accept) begin
                r_addr       <= {bus.cmd_addr[63:6], 6'b0};
                r_beats_left <= bus.cmd_beats;
                r_rx_left    <= bus.cmd_beats;
                r_err        <= 1'b0;
                r_done       <= (bus.cmd_beats == 24'd0);
            end
            if (w_issue) begin
                r_arvalid <= 1'b1;
                r_araddr  <= r_addr;
                r_arlen   <= 8'(w_n - 9'd1);
            end else if (w_ar_hs) begin
                r_arvalid    <= 1'b0;
                r_addr       <= r_addr + {49'd0, w_hs_beats, 6'd0};
                r_beats_left <= r_beats_left - {15'd0, w_hs_beats};
            end
            if (w_r_cnt) begin
                r_rx_left <= r_rx_left - 24'd1;
                if (bus.m_axi_cu_rresp_rs != 2'b00) r_err <= 1'b1;
            end
            case ({w_ar_hs, w_r_cnt & bus.m_axi_cu_rlast_rs & (r_outstanding != 9'd0)})
                2'b10:   r_outstanding <= r_outstanding + 9'd1;
                2'b01:   r_outstanding <= r_outstanding - 9'd1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

`ifdef DDR_RD_BURST_STAT_EN
    logic [31:0] r_stat_bursts;
    logic [31:0] r_stat_err_beats;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge user_clk) begin
        if (!reset_n) begin
            r_stat_bursts    <= '0;
            r_stat_err_beats <= '0;
        end else begin
            if (w_ar_hs) r_stat_bursts <= sat_inc(r_stat_bursts);
            if (w_r_hs && (bus.m_axi_cu_rresp_rs != 2'b00))
                r_stat_err_beats <= sat_inc(r_stat_err_beats);
        end
    end

    assign bus.stat_bursts    = r_stat_bursts;
    assign bus.stat_err_beats = r_stat_err_beats;
`endif

    assign bus.cmd_ready           = w_cmd_ready;
    assign bus.m_axi_cu_arvalid_rs = r_arvalid;
    assign bus.m_axi_cu_araddr_rs  = r_araddr;
    assign bus.m_axi_cu_arlen_rs   = r_arlen;
    assign bus.m_axi_cu_rready_rs  = bus.d_ready;
    assign bus.d_valid             = bus.m_axi_cu_rvalid_rs;
    assign bus.d_data              = bus.m_axi_cu_rdata_rs;
    assign bus.d_last              = bus.m_axi_cu_rvalid_rs & w_active & w_rx_last;
    assign bus.done                = r_done;
    assign bus.err                 = r_err;
endmodule

// File: tb/tb_ddr_rd_burst_gen.sv
// Directed bench for ddr_rd_burst_gen: AXI read slave model plus per-scenario tasks.
`timescale 1ns/1ps
module tb_ddr_rd_burst_gen;
    logic user_clk = 1'b0;
    logic reset_n;

    ddr_rd_burst_gen_if bus();

    ddr_rd_burst_gen #(.MAX_BURST(64), .MAX_OUTSTANDING(2)) dut (
        .user_clk (user_clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    always #5 user_clk = ~user_clk;

    int tests_run = 0;
    int tests_failed = 0;

    // slave controls
    int stall_req = 0;
    bit r_en = 1'b0;
    bit rand_dready = 1'b0;
    int err_beat = -1;

    // slave state
    logic [63:0] bq_addr[$];
    int          bq_len[$];
    int          beat_in_burst = 0;
    int          rbeat_total = 0;

    // monitor records
    logic [63:0]  ar_addr_q[$];
    int           ar_len_q[$];
    int           ar_rlast_q[$];
    logic [511:0] d_data_q[$];
    bit           d_last_q[$];
    int done_cnt = 0, rlast_cnt = 0, stab_err = 0, stall_cycles = 0, mirror_err = 0;
    bit err_at_done = 1'b0;
    bit prev_ar_wait = 1'b0;
    logic [63:0] prev_araddr = '0;
    logic [7:0]  prev_arlen = '0;

    // Drive at negedge, then record the handshakes that the next posedge will complete
    initial begin
        bus.m_axi_cu_arready_rs = 1'b0;
        bus.m_axi_cu_rvalid_rs  = 1'b0;
        bus.m_axi_cu_rdata_rs   = '0;
        bus.m_axi_cu_rlast_rs   = 1'b0;
        bus.m_axi_cu_rresp_rs   = 2'b00;
        bus.d_ready             = 1'b0;
        forever begin
            @(negedge user_clk);
            if (stall_req > 0 && bus.m_axi_cu_arvalid_rs) begin
                bus.m_axi_cu_arready_rs = 1'b0;
                stall_req--;
            end else begin
                bus.m_axi_cu_arready_rs = 1'b1;
            end
            if (r_en && bq_addr.size() > 0) begin
                bus.m_axi_cu_rvalid_rs = 1'b1;
                bus.m_axi_cu_rdata_rs  = {8{bq_addr[0] + 64'(beat_in_burst * 64)}};
                bus.m_axi_cu_rlast_rs  = (beat_in_burst == bq_len[0]);
                bus.m_axi_cu_rresp_rs  = (rbeat_total == err_beat) ? 2'b10 : 2'b00;
            end else begin
                bus.m_axi_cu_rvalid_rs = 1'b0;
                bus.m_axi_cu_rdata_rs  = '0;
                bus.m_axi_cu_rlast_rs  = 1'b0;
                bus.m_axi_cu_rresp_rs  = 2'b00;
            end
            bus.d_ready = rand_dready ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (bus.m_axi_cu_rready_rs !== bus.d_ready) mirror_err++;
            if (prev_ar_wait && (bus.m_axi_cu_arvalid_rs !== 1'b1 ||
                bus.m_axi_cu_araddr_rs !== prev_araddr || bus.m_axi_cu_arlen_rs !== prev_arlen))
                stab_err++;
            prev_ar_wait = bus.m_axi_cu_arvalid_rs & ~bus.m_axi_cu_arready_rs;
            prev_araddr  = bus.m_axi_cu_araddr_rs;
            prev_arlen   = bus.m_axi_cu_arlen_rs;
            if (prev_ar_wait) stall_cycles++;
            if (bus.m_axi_cu_arvalid_rs && bus.m_axi_cu_arready_rs) begin
                ar_addr_q.push_back(bus.m_axi_cu_araddr_rs);
                ar_len_q.push_back(int'(bus.m_axi_cu_arlen_rs));
                ar_rlast_q.push_back(rlast_cnt);
                bq_addr.push_back(bus.m_axi_cu_araddr_rs);
                bq_len.push_back(int'(bus.m_axi_cu_arlen_rs));
            end
            if (bus.d_valid && bus.d_ready) begin
                d_data_q.push_back(bus.d_data);
                d_last_q.push_back(bus.d_last);
            end
            if (bus.m_axi_cu_rvalid_rs && bus.m_axi_cu_rready_rs) begin
                rbeat_total++;
                if (bus.m_axi_cu_rlast_rs) begin
                    void'(bq_addr.pop_front());
                    void'(bq_len.pop_front());
                    beat_in_burst = 0;
                    rlast_cnt++;
                end else begin
                    beat_in_burst++;
                end
            end
            if (bus.done) begin
                done_cnt++;
                err_at_done = bus.err;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge user_clk);
        #2;
    endtask

    task automatic clear_mon();
        ar_addr_q.delete(); ar_len_q.delete(); ar_rlast_q.delete();
        d_data_q.delete(); d_last_q.delete();
        done_cnt = 0; rlast_cnt = 0; stab_err = 0; stall_cycles = 0; mirror_err = 0;
        rbeat_total = 0; err_beat = -1; err_at_done = 1'b0;
    endtask

    task automatic send_cmd(input logic [63:0] addr, input logic [23:0] beats);
        int n = 0;
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = addr;
        bus.cmd_beats = beats;
        while (!bus.cmd_ready && n < 50) begin
            step();
            n++;
        end
        step();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start = done_cnt;
        int n = 0;
        while (done_cnt == start && n < budget) begin
            step();
            n++;
        end
        ok = (done_cnt != start);
    endtask

    // Number of recorded beats that differ from a linear stream starting at base
    function automatic int bad_beats(input logic [63:0] base, input int n);
        int bad = 0;
        for (int i = 0; i < n; i++) begin
            if (i >= d_data_q.size()) bad++;
            else if (d_data_q[i] !== {8{base + 64'(i * 64)}} || d_last_q[i] !== (i == n - 1)) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_beats = '0;
        repeat (3) step();
        tests_run++;
        if (bus.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
        tests_run++;
        if (bus.m_axi_cu_arvalid_rs !== 1'b0) begin tests_failed++; $display("FAIL reset_arvalid: got %b expected 0", bus.m_axi_cu_arvalid_rs); end
        tests_run++;
        if ({bus.done, bus.err, bus.d_last} !== 3'b000) begin tests_failed++; $display("FAIL reset_done_err_last: got %b expected 000", {bus.done, bus.err, bus.d_last}); end
        tests_run++;
        if ({bus.m_axi_cu_araddr_rs, bus.m_axi_cu_arlen_rs} !== 72'd0) begin tests_failed++; $display("FAIL reset_araddr_arlen: got %h expected 0", {bus.m_axi_cu_araddr_rs, bus.m_axi_cu_arlen_rs}); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_basic_split();
        bit ok;
        clear_mon();
        r_en = 1'b1;
        send_cmd(64'h1000, 24'd100);
        wait_done(2000, ok);
        repeat (3) step();
        tests_run++;
        if (!ok) begin tests_failed++; $display("FAIL split_done_timeout: got no done expected done"); end
        tests_run++;
        if (ar_addr_q.size() != 2 || ar_addr_q[0] !== 64'h1000 || ar_len_q[0] != 63 || ar_addr_q[1] !== 64'h2000 || ar_len_q[1] != 35) begin
            tests_failed++;
            $display("FAIL split_ars: got n=%0d (%h,%0d) (%h,%0d) expected (1000,63) (2000,35)", ar_addr_q.size(), ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1]);
        end
        tests_run++;
        if (d_data_q.size() != 100 || bad_beats(64'h1000, 100) != 0) begin tests_failed++; $display("FAIL split_beats: got n=%0d bad=%0d expected n=100 bad=0", d_data_q.size(), bad_beats(64'h1000, 100)); end
        tests_run++;
        if (done_cnt != 1) begin tests_failed++; $display("FAIL split_done_count: got %0d expected 1", done_cnt); end
    endtask

    task automatic test_4k_cross();
        bit ok;
        clear_mon();
        send_cmd(64'h0FC7, 24'd3);
        wait_done(500, ok);
        tests_run++;
        if (!ok || ar_addr_q.size() != 2 || ar_addr_q[0] !== 64'h0FC0 || ar_len_q[0] != 0 || ar_addr_q[1] !== 64'h1000 || ar_len_q[1] != 1) begin
            tests_failed++;
            $display("FAIL cross4k_ars: got ok=%0d n=%0d (%h,%0d) (%h,%0d) expected (fc0,0) (1000,1)", ok, ar_addr_q.size(), ar_addr_q[0], ar_len_q[0], ar_addr_q[1], ar_len_q[1]);
        end
        tests_run++;
        if (d_data_q.size() != 3 || bad_beats(64'h0FC0, 3) != 0) begin tests_failed++; $display("FAIL cross4k_beats: got n=%0d bad=%0d expected n=3 bad=0", d_data_q.size(), bad_beats(64'h0FC0, 3)); end
    endtask

    task automatic test_outstanding();
        bit ok;
        clear_mon();
        r_en = 1'b0;
        send_cmd(64'h0, 24'd256);
        repeat (30) step();
        tests_run++;
        if (ar_addr_q.size() != 2 || bus.m_axi_cu_arvalid_rs !== 1'b0) begin tests_failed++; $display("FAIL outst_cap: got ars=%0d arvalid=%b expected ars=2 arvalid=0", ar_addr_q.size(), bus.m_axi_cu_arvalid_rs); end
        r_en = 1'b1;
        wait_done(3000, ok);
        tests_run++;
        if (!ok || ar_addr_q.size() != 4 || ar_addr_q[2] !== 64'h2000 || ar_addr_q[3] !== 64'h3000 || ar_len_q[3] != 63) begin
            tests_failed++;
            $display("FAIL outst_ars: got ok=%0d n=%0d a2=%h a3=%h l3=%0d expected n=4 a2=2000 a3=3000 l3=63", ok, ar_addr_q.size(), ar_addr_q[2], ar_addr_q[3], ar_len_q[3]);
        end
        tests_run++;
        if (ar_rlast_q.size() < 3 || ar_rlast_q[2] < 1) begin tests_failed++; $display("FAIL outst_third_after_rlast: got rlasts_before_third=%0d expected >=1", (ar_rlast_q.size() > 2) ? ar_rlast_q[2] : -1); end
        tests_run++;
        if (d_data_q.size() != 256 || bad_beats(64'h0, 256) != 0) begin tests_failed++; $display("FAIL outst_beats: got n=%0d bad=%0d expected n=256 bad=0", d_data_q.size(), bad_beats(64'h0, 256)); end
    endtask

    task automatic test_backpressure();
        bit ok;
        clear_mon();
        rand_dready = 1'b1;
        stall_req = 5;
        send_cmd(64'h10000, 24'd130);
        wait_done(5000, ok);
        rand_dready = 1'b0;
        tests_run++;
        if (!ok || stall_cycles != 5 || stab_err != 0) begin tests_failed++; $display("FAIL bp_ar_stall: got ok=%0d stall=%0d unstable=%0d expected stall=5 unstable=0", ok, stall_cycles, stab_err); end
        tests_run++;
        if (mirror_err != 0) begin tests_failed++; $display("FAIL bp_rready_mirror: got %0d mismatching cycles expected 0", mirror_err); end
        tests_run++;
        if (ar_addr_q.size() != 3 || ar_addr_q[1] !== 64'h11000 || ar_addr_q[2] !== 64'h12000 || ar_len_q[2] != 1) begin
            tests_failed++;
            $display("FAIL bp_ars: got n=%0d a1=%h a2=%h l2=%0d expected n=3 a1=11000 a2=12000 l2=1", ar_addr_q.size(), ar_addr_q[1], ar_addr_q[2], ar_len_q[2]);
        end
        tests_run++;
        if (d_data_q.size() != 130 || bad_beats(64'h10000, 130) != 0) begin tests_failed++; $display("FAIL bp_beats: got n=%0d bad=%0d expected n=130 bad=0", d_data_q.size(), bad_beats(64'h10000, 130)); end
    endtask

    task automatic test_error();
        bit ok;
        clear_mon();
        err_beat = 4;
        send_cmd(64'h4000, 24'd10);
        wait_done(500, ok);
        repeat (2) step();
        tests_run++;
        if (!ok || err_at_done !== 1'b1 || bus.err !== 1'b1) begin tests_failed++; $display("FAIL err_sticky: got ok=%0d at_done=%b now=%b expected 1 1", ok, err_at_done, bus.err); end
        tests_run++;
        if (d_data_q.size() != 10 || bad_beats(64'h4000, 10) != 0) begin tests_failed++; $display("FAIL err_beats_forwarded: got n=%0d expected 10", d_data_q.size()); end
        send_cmd(64'h8000, 24'd1);
        tests_run++;
        if (bus.err !== 1'b0) begin tests_failed++; $display("FAIL err_clear_on_accept: got %b expected 0", bus.err); end
        wait_done(500, ok);
        tests_run++;
        if (!ok || err_at_done !== 1'b0) begin tests_failed++; $display("FAIL err_clean_cmd: got ok=%0d err=%b expected ok=1 err=0", ok, err_at_done); end
    endtask

    task automatic test_zero_beats();
        clear_mon();
        send_cmd(64'h5000, 24'd0);
        tests_run++;
        if (bus.done !== 1'b1 || bus.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL zero_done: got done=%b ready=%b expected 1 1", bus.done, bus.cmd_ready); end
        repeat (10) step();
        tests_run++;
        if (done_cnt != 1 || ar_addr_q.size() != 0 || bus.done !== 1'b0) begin tests_failed++; $display("FAIL zero_no_ar: got dones=%0d ars=%0d expected 1 0", done_cnt, ar_addr_q.size()); end
    endtask

    task automatic test_reset_mid();
        bit ok;
        clear_mon();
        r_en = 1'b0;
        stall_req = 1000;
        send_cmd(64'h20000, 24'd50);
        repeat (5) step();
        tests_run++;
        if (bus.m_axi_cu_arvalid_rs !== 1'b1) begin tests_failed++; $display("FAIL rstmid_pending_ar: got %b expected 1", bus.m_axi_cu_arvalid_rs); end
        reset_n = 1'b0;
        step();
        tests_run++;
        if (bus.m_axi_cu_arvalid_rs !== 1'b0 || bus.cmd_ready !== 1'b1) begin tests_failed++; $display("FAIL rstmid_idle: got arvalid=%b ready=%b expected 0 1", bus.m_axi_cu_arvalid_rs, bus.cmd_ready); end
        reset_n = 1'b1;
        stall_req = 0;
        bq_addr.delete(); bq_len.delete(); beat_in_burst = 0;
        repeat (10) step();
        tests_run++;
        if (ar_addr_q.size() != 0 || bus.m_axi_cu_arvalid_rs !== 1'b0) begin tests_failed++; $display("FAIL rstmid_no_ar: got ars=%0d arvalid=%b expected 0 0", ar_addr_q.size(), bus.m_axi_cu_arvalid_rs); end
        // Stray beat while idle: forwarded, never marked last
        r_en = 1'b1;
        bq_addr.push_back(64'h9000); bq_len.push_back(0);
        step();
        tests_run++;
        if (bus.d_valid !== 1'b1 || bus.d_last !== 1'b0 || bus.d_data !== {8{64'h9000}}) begin tests_failed++; $display("FAIL idle_beat: got valid=%b last=%b expected 1 0", bus.d_valid, bus.d_last); end
        repeat (3) step();
        clear_mon();
        send_cmd(64'h3000, 24'd2);
        wait_done(500, ok);
        tests_run++;
        if (!ok || ar_addr_q.size() != 1 || bad_beats(64'h3000, 2) != 0) begin tests_failed++; $display("FAIL rstmid_recover: got ok=%0d ars=%0d beats=%0d expected 1 1 2", ok, ar_addr_q.size(), d_data_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic_split();
        test_4k_cross();
        test_outstanding();
        test_backpressure();
        test_error();
        test_zero_beats();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ddr_rd_burst_gen.md
Name: ddr_rd_burst_gen

Overview:
- Read-command engine on the DDR read path, directly upstream of the AXI read register slice (`_rs` side).
- Accepts one read command at a time (64-bit byte address, length in 64-byte beats).
- Splits each command into AXI INCR bursts that never cross a 4 KB boundary and caps the number of outstanding bursts.
- Returns read data as a beat stream with end-of-command marking; each command ends with a done pulse and a sticky error flag.

Parameters:
MAX_BURST, 64, max beats per AR burst (1..256); arlen = beats-1
MAX_OUTSTANDING, 8, max AR bursts issued but without rlast received (1..255)

Ports:
user_clk  in  1  clock, all logic on rising edge
reset_n  in  1  synchronous active-low reset
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted when valid&ready
cmd_addr  in  64  start byte address; bits [5:0] ignored (forced 0)
cmd_beats  in  24  command length in 64 B beats
m_axi_cu_arvalid_rs  out  1  AR valid toward register slice
m_axi_cu_araddr_rs  out  64  AR address
m_axi_cu_arlen_rs  out  8  AR burst length-1
m_axi_cu_arready_rs  in  1  AR ready from register slice
m_axi_cu_rvalid_rs  in  1  R valid
m_axi_cu_rdata_rs  in  512  R data
m_axi_cu_rlast_rs  in  1  R last beat of burst
m_axi_cu_rresp_rs  in  2  R response
m_axi_cu_rready_rs  out  1  R ready
d_valid  out  1  data stream valid
d_data  out  512  data stream payload
d_last  out  1  last beat of whole command
d_ready  in  1  downstream ready
done  out  1  one-cycle pulse at command completion
err  out  1  sticky: any rresp!=0 in current command; cleared on command accept

Behaviour:
- Reset (reset_n=0 at clock edge): state IDLE; arvalid, done, err, counters = 0; araddr, arlen = 0.
- FSM states: IDLE, ISSUE, DRAIN.
- IDLE:
  - cmd_ready=1 only in IDLE.
  - On accept: latch addr{[63:6],6'b0}, beats_left=cmd_beats, rx_left=cmd_beats; clear err.
  - cmd_beats=0 -> stay IDLE, assert done next cycle, no AR issued.
  - Otherwise -> ISSUE.
- ISSUE:
  - Burst size n = min(beats_left, MAX_BURST, 64-addr[11:6]).
  - Registered AR: when arvalid=0 and outstanding<MAX_OUTSTANDING, drive arvalid=1, araddr=addr, arlen=n-1 on the next edge.
  - Fields are held stable until arready=1.
  - On handshake: addr+=n*64, beats_left-=n, outstanding+1, arvalid drops (at most one AR per 2 cycles is acceptable).
  - beats_left reaches 0 on handshake -> DRAIN.
- Outstanding counter:
  - +1 on AR handshake; -1 on R handshake with rlast.
  - Both in the same cycle -> unchanged.
  - Never exceeds MAX_OUTSTANDING.
- R path (combinational pass-through, zero latency):
  - d_valid=rvalid_rs; d_data=rdata_rs; rready_rs=d_ready.
  - d_last = rvalid_rs & (rx_left==1).
  - rx_left decrements on each R handshake.
  - Any handshake beat with rresp!=0 sets err; data is still forwarded.
  - R beats arriving in IDLE (protocol violation) are forwarded; d_last=0; counters unchanged.
- DRAIN: when the R handshake with rx_left==1 occurs -> IDLE, done=1 for one cycle (the cycle after). A new command may be accepted in that same IDLE cycle.
- Address arithmetic is 64-bit unsigned; wrap at 2^64 is not checked.
- Reset mid-command: all state discarded immediately; no further AR issued; late R beats are treated as the IDLE case.

Optional Feature:
DDR_RD_BURST_STAT_EN
- Defined: adds outputs stat_bursts (32 b) and stat_err_beats (32 b).
  - stat_bursts counts AR handshakes.
  - stat_err_beats counts R beats with rresp!=0.
  - Both saturate at 0xFFFFFFFF; reset to 0; never cleared by commands.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Basic split: cmd_addr=0x1000, cmd_beats=100, MAX_BURST=64, slave always ready.
  - Expect ARs (0x1000, len 63), (0x2000, len 35).
  - 100 d beats; d_last only on beat 100; done once.
- 4 KB crossing: cmd_addr=0x0FC0, cmd_beats=3.
  - Expect ARs (0x0FC0, len 0), (0x1000, len 1).
- Outstanding cap: MAX_OUTSTANDING=2, cmd_beats=256, rvalid held 0.
  - Exactly 2 ARs issued, then arvalid stays 0.
  - After first rlast handshake, third AR issued.
- Backpressure: d_ready toggled randomly and arready stalled 5 cycles while arvalid=1.
  - araddr/arlen stable throughout the stall; rready_rs mirrors d_ready; no beat lost or duplicated.
- Error/zero/reset cases:
  - rresp=2'b10 on beat 5 of 10 -> err=1 through done; err cleared on next command accept.
  - cmd_beats=0 -> done pulse, no AR.
  - reset_n=0 mid-ISSUE -> arvalid=0 next cycle, state IDLE.
